// File: rtl/fwd_if.sv
// Handshake bundle between the ID stage and the forwarding/hazard controller.
// master = ID/pipeline side, slave = fwd_ctrl.
interface fwd_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic             stall;
  logic             fwd_a_s1;
  logic             fwd_a_s0;
  logic             fwd_b_s1;
  logic             fwd_b_s0;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_regwrite, id_memread, flush,
    input  stall, fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall_count
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_regwrite, id_memread, flush,
    output stall, fwd_a_s1, fwd_a_s0, fwd_b_s1, fwd_b_s0, stall_count
  );
endinterface

// File: rtl/fwd_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Define FWD_STALL_CNT_EN to build the saturating stall_count; otherwise it is tied to 0.
module fwd_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic  clk,
  input  logic  reset,
  fwd_if.slave  bus
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b01;
  localparam logic [1:0] SEL_MWB  = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // p1 = shadow of the instruction now in EX, p2 = shadow of the one in MEM
  logic             vld_p1, regwr_p1, memrd_p1;
  logic [REG_W-1:0] rd_p1;
  logic             vld_p2, regwr_p2, memrd_p2;
  logic [REG_W-1:0] rd_p2;

  logic [1:0]       sel_a_p1, sel_b_p1;
  logic [1:0]       sel_a, sel_b;
  logic             hazard;
  logic             issue;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             v1,
    input logic             w1,
    input logic [REG_W-1:0] r1,
    input logic             v2,
    input logic             w2,
    input logic [REG_W-1:0] r2
  );
    logic [1:0] s;
    if (src == ZR)
      s = SEL_ZERO;
    else if (v1 && w1 && (r1 == src) && (r1 != ZR))
      s = SEL_EXM;
    else if (v2 && w2 && (r2 == src) && (r2 != ZR))
      s = SEL_MWB;
    else
      s = SEL_RF;
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: ID-side decode against the shadows
  always_comb begin
    sel_a  = fwd_sel(bus.id_rn, vld_p1, regwr_p1, rd_p1, vld_p2, regwr_p2, rd_p2);
    sel_b  = fwd_sel(bus.id_rm, vld_p1, regwr_p1, rd_p1, vld_p2, regwr_p2, rd_p2);
    hazard = bus.id_valid && vld_p1 && memrd_p1 && regwr_p1 && (rd_p1 != ZR) &&
             ((rd_p1 == bus.id_rn) || (rd_p1 == bus.id_rm));
    issue  = bus.id_valid && !hazard && !bus.flush;
  end

  assign bus.stall = hazard;

  // Stage p1/p2: control state (valid bits and registered selects)
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      sel_a_p1 <= SEL_RF;
      sel_b_p1 <= SEL_RF;
    end else begin
      vld_p2   <= vld_p1;
      vld_p1   <= issue;
      sel_a_p1 <= issue ? sel_a : SEL_RF;
      sel_b_p1 <= issue ? sel_b : SEL_RF;
    end
  end

  // Shadow payload is qualified by vld_pN, so it carries no reset
  always_ff @(posedge clk) begin
    rd_p2    <= rd_p1;
    regwr_p2 <= regwr_p1;
    memrd_p2 <= memrd_p1;
    rd_p1    <= bus.id_rd;
    regwr_p1 <= bus.id_regwrite;
    memrd_p1 <= bus.id_memread;
  end

  assign bus.fwd_a_s1 = sel_a_p1[1];
  assign bus.fwd_a_s0 = sel_a_p1[0];
  assign bus.fwd_b_s1 = sel_b_p1[1];
  assign bus.fwd_b_s0 = sel_b_p1[0];

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_p1 <= '0;
    else if (hazard)
      cnt_p1 <= sat_inc(cnt_p1);
  end

  assign bus.stall_count = cnt_p1;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Randomized scoreboard bench for fwd_ctrl against a slot-history reference model.
module tb_fwd_ctrl;
  localparam int RW = 5;
  localparam int CW = 2;
  localparam int ZR = 31;
`ifdef FWD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_if #(.REG_W(RW), .CNT_W(CW)) bus ();

  fwd_ctrl #(.REG_W(RW), .ZERO_REG(ZR), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } slot_t;

  typedef struct {
    bit       st;
    bit [1:0] a;
    bit [1:0] b;
    int       cnt;
  } exp_t;

  exp_t  exp_q[$];
  slot_t pipe[$];      // pipe[0] = in EX, pipe[1] = in MEM
  bit [1:0] exp_a, exp_b;
  int cnt_m;
  int checks = 0;
  int errors = 0;

  function automatic bit [1:0] ref_sel(bit [4:0] src);
    if (src == ZR) return 2'd3;
    if (pipe[0].v && pipe[0].rw && pipe[0].rd == src && pipe[0].rd != ZR) return 2'd1;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == src && pipe[1].rd != ZR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit ref_stall(bit v, bit [4:0] rn, bit [4:0] rm);
    return v && pipe[0].v && pipe[0].mr && pipe[0].rw && pipe[0].rd != ZR &&
           (pipe[0].rd == rn || pipe[0].rd == rm);
  endfunction

  task automatic model_reset();
    slot_t b;
    b = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    pipe.delete();
    pipe.push_back(b);
    pipe.push_back(b);
    exp_a = 2'd0;
    exp_b = 2'd0;
    cnt_m = 0;
  endtask

  // One ID cycle: drive, record expected outputs for this cycle, then advance the model.
  task automatic drive(bit v, bit [4:0] rn, bit [4:0] rm, bit [4:0] rd,
                       bit rw, bit mr, bit fl, bit rst);
    exp_t  e;
    slot_t s;
    bit    st;
    reset           = rst;
    bus.id_valid    = v;
    bus.id_rn       = rn;
    bus.id_rm       = rm;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.flush       = fl;
    st = ref_stall(v, rn, rm);
    e = '{st: st, a: exp_a, b: exp_b, cnt: cnt_m};
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (st && CNT_EN) cnt_m = (cnt_m < (1 << CW) - 1) ? cnt_m + 1 : cnt_m;
      if (st || fl || !v) begin
        s = '{v: 1'b0, rd: rd, rw: rw, mr: mr};
        exp_a = 2'd0;
        exp_b = 2'd0;
      end else begin
        s = '{v: 1'b1, rd: rd, rw: rw, mr: mr};
        exp_a = ref_sel(rn);
        exp_b = ref_sel(rm);
      end
      pipe.push_front(s);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall", int'(bus.stall), int'(e.st));
      check("fwd_a", int'({bus.fwd_a_s1, bus.fwd_a_s0}), int'(e.a));
      check("fwd_b", int'({bus.fwd_b_s1, bus.fwd_b_s0}), int'(e.b));
      check("stall_count", int'(bus.stall_count), e.cnt);
    end
  end

  function automatic bit [4:0] pick();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_rn = '0; bus.id_rm = '0; bus.id_rd = '0;
    bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    drive(0, 0, 0, 0, 0, 0, 0, 1);           // reset state
    drive(1, 3, 3, 1, 1, 0, 0, 0);           // ADD X1
    drive(1, 1, 3, 2, 1, 0, 0, 0);           // ADD X2,X1,X3 -> a=01
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 3, 1, 1, 0, 0, 0);           // ADD X1
    drive(0, 0, 0, 0, 0, 0, 0, 0);           // NOP
    drive(1, 5, 1, 4, 1, 0, 0, 0);           // SUB X4,X5,X1 -> b=10
    drive(1, 3, 3, 1, 1, 0, 0, 0);           // X1 again
    drive(1, 3, 3, 1, 1, 0, 0, 0);           // X1 in d1 and d2
    drive(1, 1, 1, 4, 1, 0, 0, 0);           // -> 01,01
    drive(1, 3, 3, 2, 1, 1, 0, 0);           // LDUR X2
    drive(1, 2, 2, 3, 1, 0, 0, 0);           // stalls
    drive(1, 2, 2, 3, 1, 0, 0, 0);           // re-issue -> 10,10
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 3, 31, 1, 1, 0, 0);          // load to XZR
    drive(1, 31, 31, 4, 1, 0, 0, 0);         // 11,11 no stall
    drive(1, 3, 3, 2, 1, 1, 0, 0);           // LDUR X2
    drive(1, 2, 3, 3, 1, 0, 1, 0);           // stall + flush
    drive(1, 2, 3, 3, 1, 0, 0, 0);
    drive(1, 3, 3, 2, 1, 1, 0, 0);           // LDUR X2
    drive(1, 2, 2, 3, 1, 0, 0, 1);           // reset during stall
    drive(1, 2, 2, 3, 1, 0, 0, 0);           // no stall afterwards
    for (int k = 0; k < 5; k++) begin        // five load-use hazards
      drive(1, 3, 3, 2, 1, 1, 0, 0);
      drive(1, 2, 0, 4, 1, 0, 0, 0);
      drive(1, 2, 0, 4, 1, 0, 0, 0);
    end

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 7) != 0, pick(), pick(), pick(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
